// File: rtl/adat_frame_serializer.sv
// ADAT frame transmitter: latches eight 24-bit channels plus the user nibble once per
// 256-bit frame and drives the NRZI-encoded line at one frame bit per clock.
module adat_frame_serializer #(
    parameter int REQUEST_LEAD = 16,
    parameter bit INVERT_OUT   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [7:0][23:0] audio_bus,
    input  logic [3:0]              user_bits,
    output logic                    data_request,
    output logic                    frame_start,
    output logic                    adat_bitstream
);

    localparam logic [7:0] REQ_IDX  = 8'(256 - REQUEST_LEAD);
    localparam logic       LINE_RST = INVERT_OUT;

    logic         r_started;
    logic [7:0]   r_bit_idx;
    logic [2:0]   r_pos;
    logic [191:0] r_shift;
    logic [3:0]   r_user;
    logic         r_req;
    logic         r_fs;
    logic         r_line;

    logic [7:0]   w_next_idx;
    logic [191:0] w_payload;
    logic         w_in_data;
    logic [1:0]   w_user_sel;
    logic         w_bit;

    // The first edge after reset release only arms the counter, so index 0
    // (and frame_start) occupies the first full cycle after release.
    assign w_next_idx = r_started ? r_bit_idx + 8'd1 : 8'd0;
    assign w_payload  = {audio_bus[0], audio_bus[1], audio_bus[2], audio_bus[3],
                         audio_bus[4], audio_bus[5], audio_bus[6], audio_bus[7]};
    assign w_in_data  = (r_bit_idx[7:4] != 4'd0);
    assign w_user_sel = ~r_bit_idx[1:0];

    always_comb begin
        w_bit = 1'b0;
        if (w_in_data)
            w_bit = (r_pos == 3'd0) ? 1'b1 : r_shift[191];
        else if (r_bit_idx == 8'd0 || r_bit_idx == 8'd11)
            w_bit = 1'b1;
        else if (r_bit_idx >= 8'd12)
            w_bit = r_user[w_user_sel];
    end

    // Payload shadow is consumed as a shift register: each data slot takes the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started <= 1'b0;
            r_bit_idx <= 8'd0;
            r_pos     <= 3'd0;
            r_shift   <= '0;
            r_user    <= 4'd0;
            r_req     <= 1'b0;
            r_fs      <= 1'b0;
            r_line    <= LINE_RST;
        end else begin
            r_started <= 1'b1;
            r_bit_idx <= w_next_idx;
            r_fs      <= (w_next_idx == 8'd0);
            r_req     <= (w_next_idx == REQ_IDX);
            if (r_started) begin
                r_line <= r_line ^ w_bit;
                r_pos  <= (r_bit_idx == 8'd15 || r_pos == 3'd4) ? 3'd0 : 3'(r_pos + 3'd1);
                if (r_bit_idx == 8'd255) begin
                    r_shift <= w_payload;
                    r_user  <= user_bits;
                end else if (w_in_data && r_pos != 3'd0) begin
                    r_shift <= {r_shift[190:0], 1'b0};
                end
            end
        end
    end

    assign data_request   = r_req;
    assign frame_start    = r_fs;
    assign adat_bitstream = r_line;

endmodule

// File: tb/tb_adat_frame_serializer.sv
// Scoreboard bench: a frame-level model predicts every cycle's outputs of two
// instances (default lead / lead 100 with inverted line); a monitor compares.
module tb_adat_frame_serializer;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0][23:0] audio = '0;
    logic [3:0]       user = 4'd0;
    logic             req1, fs1, line1, req2, fs2, line2;

    always #5 clk = ~clk;

    adat_frame_serializer #(.REQUEST_LEAD(16), .INVERT_OUT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .audio_bus(audio), .user_bits(user),
        .data_request(req1), .frame_start(fs1), .adat_bitstream(line1));

    adat_frame_serializer #(.REQUEST_LEAD(100), .INVERT_OUT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .audio_bus(audio), .user_bits(user),
        .data_request(req2), .frame_start(fs2), .adat_bitstream(line2));

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] q[$];

    bit           m_started = 1'b0;
    int           m_idx = 0;
    logic         m_line = 1'b0;
    logic [255:0] m_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Frame bits indexed by bit position, straight from the frame layout rules.
    function automatic logic [255:0] build(input logic [7:0][23:0] a, input logic [3:0] u);
        logic [255:0] f;
        int ch, nb;
        f = '0;
        f[0]  = 1'b1;
        f[11] = 1'b1;
        for (int j = 0; j < 4; j++) f[12+j] = u[3-j];
        for (int k = 0; k < 48; k++) begin
            ch = k / 6;
            nb = k % 6;
            f[16+5*k] = 1'b1;
            for (int j = 0; j < 4; j++) f[17+5*k+j] = a[ch][23-4*nb-j];
        end
        return f;
    endfunction

    function automatic logic [5:0] expect_now();
        logic fs, r1, r2;
        fs = m_started && m_idx == 0;
        r1 = m_started && m_idx == 240;
        r2 = m_started && m_idx == 156;
        return {m_line, fs, r1, ~m_line, fs, r2};
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_idx     = 0;
        m_line    = 1'b0;
        m_frame   = build('0, 4'd0);
    endtask

    task automatic model_edge();
        if (rst) model_reset();
        else if (!m_started) begin
            m_started = 1'b1;
            m_idx     = 0;
        end else begin
            m_line = m_line ^ m_frame[m_idx];
            if (m_idx == 255) m_frame = build(audio, user);
            m_idx = (m_idx + 1) % 256;
        end
        q.push_back(expect_now());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_idx(input int t);
        for (int n = 0; n < 300 && m_idx != t; n++) step();
        check("wait_idx", 32'(m_idx), 32'(t));
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < 8; c++) audio[c] = 24'($urandom);
        user = 4'($urandom);
    endtask

    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cycle_outputs", 32'({line1, fs1, req1, line2, fs2, req2}), 32'(e));
            end
        end
    end

    initial begin : stim
        int toggles;
        logic prev;
        model_reset();

        // reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            step();
        end
        rst   = 1'b0;
        audio = '0;
        user  = 4'd0;
        step();

        // idle frame: 50 line transitions per frame
        toggles = 0;
        for (int i = 0; i < 256; i++) begin
            prev = line1;
            step();
            if (line1 != prev) toggles++;
        end
        check("idle_toggles", 32'(toggles), 32'd50);

        // payload mapping
        wait_idx(240);
        audio[0] = 24'h123456;
        audio[7] = 24'hFFFFFF;
        user     = 4'hA;
        wait_idx(0);
        wait_idx(255);
        step();
        audio = '0;
        user  = 4'd0;

        // mid-frame changes: only values present at the latch edge matter
        for (int f = 0; f < 6; f++) begin
            wait_idx(100);
            rand_inputs();
            if (f[0]) begin
                wait_idx(100 + 20 * f);
                rand_inputs();
            end
            wait_idx(0);
        end

        // asynchronous reset mid-frame
        rand_inputs();
        wait_idx(100);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'({line1, fs1, req1, line2, fs2, req2}), 32'(6'b000100));
        q.delete();
        model_reset();
        q.push_back(expect_now());
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) rand_inputs();
            step();
        end

        #10;
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
